// File: rtl/m68k_bus_decoder_if.sv
// 68000 bus bundle between CPU core and the chip-select decoder.
// Master is the CPU side; slave is the decoder.
interface m68k_bus_decoder_if #(
  parameter int NUM_REGIONS = 24,
  parameter int PCB_W       = 2,
  parameter int ADDR_W      = 24
);
  logic [PCB_W-1:0]       pcb;
  logic [ADDR_W-1:0]      m68k_a;
  logic                   m68k_as_n;
  logic                   m68k_rw;
  logic [NUM_REGIONS-1:0] region_cs;
  logic [NUM_REGIONS-1:0] region_wr_stb;
  logic                   dtack_n;
  logic                   berr_n;
  logic                   unmapped;
  logic                   overlap;

  modport master (
    output pcb, m68k_a, m68k_as_n, m68k_rw,
    input  region_cs, region_wr_stb,
    input  dtack_n, berr_n, unmapped, overlap
  );

  modport slave (
    input  pcb, m68k_a, m68k_as_n, m68k_rw,
    output region_cs, region_wr_stb,
    output dtack_n, berr_n, unmapped, overlap
  );
endinterface

// File: rtl/m68k_bus_decoder.sv
// Registered 68000 chip-select decoder with wait states and DTACK.
// Optional macro BUS_ERR_EN: unmapped accesses raise BERR after TIMEOUT.
module m68k_bus_decoder #(
  parameter int NUM_REGIONS = 24,
  parameter int NUM_PCB     = 4,
  parameter int PCB_W       = 2,
  parameter int ADDR_W      = 24,
  parameter logic [NUM_PCB*NUM_REGIONS*2*ADDR_W-1:0]
                REGION_TABLE = '0,
  parameter logic [NUM_REGIONS*4-1:0] WAIT_TABLE = '0,
  parameter int TIMEOUT     = 64
) (
  input  logic clk_sys,
  input  logic reset,
  m68k_bus_decoder_if.slave bus
);

  localparam int CNT_W =
    ($clog2(TIMEOUT+1) > 4) ? $clog2(TIMEOUT+1) : 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACK    = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  logic [2:0]             r_state;
  logic                   r_armed;
  logic [PCB_W-1:0]       r_pcb;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_rw;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_REGIONS-1:0] r_cs;
  logic [NUM_REGIONS-1:0] r_stb;
  logic                   r_dtack_n;
  logic                   r_berr_n;
  logic                   r_unmapped;
  logic                   r_overlap;

  logic [NUM_REGIONS-1:0] w_hit;
  logic [NUM_REGIONS-1:0] w_win;
  logic [3:0]             w_wait;
  logic                   w_overlap;

  // Range match of the latched address against the latched profile.
  always_comb begin
    w_hit = '0;
    if (int'(r_pcb) < NUM_PCB) begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        if (REGION_TABLE[((int'(r_pcb)*NUM_REGIONS+r)*2+1)*ADDR_W
                         +: ADDR_W] <= r_addr &&
            r_addr <= REGION_TABLE[(int'(r_pcb)*NUM_REGIONS+r)
                                   *2*ADDR_W +: ADDR_W])
          w_hit[r] = 1'b1;
      end
    end
  end

  // Lowest set hit bit wins; any other set bit flags an overlap.
  always_comb begin
    w_win     = w_hit & (-w_hit);
    w_overlap = |(w_hit & ~w_win);
    w_wait    = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (w_win[r]) w_wait = WAIT_TABLE[r*4 +: 4];
    end
  end

  // Bus cycle sequencer: latch, decode, wait, acknowledge or error.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_pcb      <= '0;
      r_addr     <= '0;
      r_rw       <= 1'b1;
      r_cnt      <= '0;
      r_cs       <= '0;
      r_stb      <= '0;
      r_dtack_n  <= 1'b1;
      r_berr_n   <= 1'b1;
      r_unmapped <= 1'b0;
      r_overlap  <= 1'b0;
    end else begin
      r_stb <= '0;
      if (r_state != S_IDLE && bus.m68k_as_n) begin
        r_state    <= S_IDLE;
        r_cnt      <= '0;
        r_cs       <= '0;
        r_dtack_n  <= 1'b1;
        r_berr_n   <= 1'b1;
        r_unmapped <= 1'b0;
        r_overlap  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_armed <= bus.m68k_as_n;
            if (r_armed && !bus.m68k_as_n) begin
              r_pcb   <= bus.pcb;
              r_addr  <= bus.m68k_a;
              r_rw    <= bus.m68k_rw;
              r_state <= S_DECODE;
            end
          end
          S_DECODE: begin
            if (w_hit == '0) begin
              r_unmapped <= 1'b1;
              r_cnt      <= '0;
              r_state    <= S_ERR;
            end else begin
              r_cs      <= w_win;
              r_overlap <= w_overlap;
              r_cnt     <= CNT_W'(w_wait);
              if (w_wait == 4'd0) begin
                r_state   <= S_ACK;
                r_dtack_n <= 1'b0;
                r_stb     <= r_rw ? '0 : w_win;
              end else begin
                r_state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state   <= S_ACK;
              r_dtack_n <= 1'b0;
              r_stb     <= r_rw ? '0 : r_cs;
            end
          end
          S_ACK: begin
            r_dtack_n <= 1'b0;
          end
          S_ERR: begin
`ifdef BUS_ERR_EN
            if (r_berr_n) begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == CNT_W'(TIMEOUT-1))
                r_berr_n <= 1'b0;
            end
`else
            r_dtack_n <= 1'b0;
`endif
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.region_cs     = r_cs;
  assign bus.region_wr_stb = r_stb;
  assign bus.dtack_n       = r_dtack_n;
  assign bus.berr_n        = r_berr_n;
  assign bus.unmapped      = r_unmapped;
  assign bus.overlap       = r_overlap;

endmodule

// File: tb/tb_m68k_bus_decoder.sv
// Bench for m68k_bus_decoder: vector table, corner sequences,
// and random accesses against a range-search reference model.
module tb_m68k_bus_decoder;
  localparam int NR    = 24;
  localparam int NP    = 4;
  localparam int PW    = 2;
  localparam int AW    = 24;
  localparam int TO    = 64;
  localparam int TBL_W = NP*NR*2*AW;

  function automatic logic [TBL_W-1:0] put(
    input logic [TBL_W-1:0] t, input int p, input int r,
    input logic [23:0] s, input logic [23:0] e);
    t[(p*NR+r)*2*AW +: 2*AW] = {s, e};
    return t;
  endfunction

  function automatic logic [TBL_W-1:0] mk_table();
    logic [TBL_W-1:0] t;
    t = '0;
    for (int p = 0; p < NP; p++)
      for (int r = 0; r < NR; r++)
        t = put(t, p, r, 24'hFFFFFF, 24'h000000);
    t = put(t, 1, 0,  24'h000000, 24'h05FFFF);
    t = put(t, 1, 5,  24'h06D00A, 24'h06D00B);
    t = put(t, 1, 6,  24'h06D000, 24'h06DFFF);
    t = put(t, 1, 10, 24'h800000, 24'h80FFFF);
    t = put(t, 2, 3,  24'h000000, 24'h0FFFFF);
    t = put(t, 2, 7,  24'h200000, 24'h2FFFFF);
    t = put(t, 0, 1,  24'h100000, 24'h1FFFFF);
    t = put(t, 0, 23, 24'hFF0000, 24'hFFFFFF);
    t = put(t, 3, 2,  24'hFFFFFF, 24'hFFFFFF);
    return t;
  endfunction

  function automatic logic [NR*4-1:0] mk_wait();
    logic [NR*4-1:0] w;
    w = '0;
    w[0*4  +: 4] = 4'd1;
    w[6*4  +: 4] = 4'd2;
    w[3*4  +: 4] = 4'd3;
    w[7*4  +: 4] = 4'd15;
    w[10*4 +: 4] = 4'd4;
    w[23*4 +: 4] = 4'd5;
    w[2*4  +: 4] = 4'd1;
    return w;
  endfunction

  localparam logic [TBL_W-1:0] TBL = mk_table();
  localparam logic [NR*4-1:0]  WT  = mk_wait();

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  m68k_bus_decoder_if #(.NUM_REGIONS(NR), .PCB_W(PW), .ADDR_W(AW)) bus();

  m68k_bus_decoder #(
    .NUM_REGIONS(NR), .NUM_PCB(NP), .PCB_W(PW), .ADDR_W(AW),
    .REGION_TABLE(TBL), .WAIT_TABLE(WT), .TIMEOUT(TO)
  ) dut (
    .clk_sys(clk),
    .reset(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input string nm,
                     input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h, expected %0h", tag, nm, got, exp);
    end
  endtask

  // Reference: scan the region list, first match wins, count matches.
  function automatic int ref_win(input int p, input logic [23:0] a,
                                 output bit ov);
    int n, win;
    logic [23:0] s, e;
    n = 0; win = -1;
    if (p >= NP) begin ov = 1'b0; return -1; end
    for (int r = 0; r < NR; r++) begin
      {s, e} = TBL[(p*NR+r)*2*AW +: 2*AW];
      if (a >= s && a <= e) begin
        n++;
        if (win < 0) win = r;
      end
    end
    ov = (n > 1);
    return win;
  endfunction

  task automatic access(input logic [1:0] p, input logic [23:0] a,
                        input logic rw, input int win, input int w,
                        input bit ov, input string tag);
    int cs_c, dt_c, be_c, un_c, stb_c, stb_n, rel, ev;
    logic [NR-1:0] cs_v, stb_v;
    bit ov1, done;
    cs_c = -1; dt_c = -1; be_c = -1; un_c = -1;
    stb_c = -1; stb_n = 0; rel = -1; done = 1'b0;
    cs_v = '0; stb_v = '0; ov1 = 1'b0;
    bus.m68k_as_n = 1'b1;
    repeat (2) @(negedge clk);
    bus.pcb = p; bus.m68k_a = a; bus.m68k_rw = rw;
    bus.m68k_as_n = 1'b0;
    for (int j = 0; j < 200 && !done; j++) begin
      @(negedge clk);
      if (rel >= 0) begin
        chk(tag, "cleared",
            {bus.region_cs, bus.dtack_n, bus.berr_n,
             bus.unmapped, bus.overlap},
            {{NR{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0});
        done = 1'b1;
      end else begin
        if (j == 0) begin
          bus.pcb = PW'($urandom);
          bus.m68k_a = AW'($urandom);
          bus.m68k_rw = ~rw;
        end
        if (j == 1) ov1 = bus.overlap;
        if (bus.region_cs != '0 && cs_c < 0) begin
          cs_c = j; cs_v = bus.region_cs;
        end
        if (bus.unmapped && un_c < 0) un_c = j;
        if (!bus.dtack_n && dt_c < 0) dt_c = j;
        if (!bus.berr_n && be_c < 0) be_c = j;
        if (bus.region_wr_stb != '0) begin
          stb_n++; stb_c = j; stb_v = bus.region_wr_stb;
        end
        ev = (dt_c >= 0) ? dt_c : be_c;
        if (ev >= 0 && j == ev + 2) begin
          bus.m68k_as_n = 1'b1;
          rel = j;
        end
      end
    end
    chk(tag, "finished", 32'(done), 32'd1);
    bus.m68k_as_n = 1'b1;
    if (win >= 0) begin
      chk(tag, "cs_val", 32'(cs_v), 32'(1) << win);
      chk(tag, "cs_cycle", cs_c, 1);
      chk(tag, "dtack_cycle", dt_c, 1 + w);
      chk(tag, "overlap", 32'(ov1), 32'(ov));
      chk(tag, "unmapped", un_c, -1);
      chk(tag, "berr", be_c, -1);
      chk(tag, "stb_count", stb_n, rw ? 0 : 1);
      if (!rw) begin
        chk(tag, "stb_val", 32'(stb_v), 32'(1) << win);
        chk(tag, "stb_cycle", stb_c, dt_c);
      end
    end else begin
      chk(tag, "cs_cycle", cs_c, -1);
      chk(tag, "unmapped_cycle", un_c, 1);
      chk(tag, "overlap", 32'(ov1), 0);
      chk(tag, "stb_count", stb_n, 0);
`ifdef BUS_ERR_EN
      chk(tag, "berr_cycle", be_c, 1 + TO);
      chk(tag, "dtack_cycle", dt_c, -1);
`else
      chk(tag, "dtack_cycle", dt_c, 2);
      chk(tag, "berr", be_c, -1);
`endif
    end
  endtask

  typedef struct {
    logic [1:0]  p;
    logic [23:0] a;
    logic        rw;
    int          win;
    int          w;
    bit          ov;
  } vec_t;

  vec_t vt[12];

  initial begin
    int   r, sel, exp_w, win;
    bit   ov;
    logic [23:0] s, e, a;
    logic [1:0]  p;

    vt[0]  = '{2'd1, 24'h001234, 1'b1, 0,  1,  1'b0};
    vt[1]  = '{2'd1, 24'h06D00A, 1'b0, 5,  0,  1'b1};
    vt[2]  = '{2'd1, 24'h06D00B, 1'b0, 5,  0,  1'b1};
    vt[3]  = '{2'd1, 24'h06D00C, 1'b1, 6,  2,  1'b0};
    vt[4]  = '{2'd1, 24'h05FFFF, 1'b0, 0,  1,  1'b0};
    vt[5]  = '{2'd1, 24'h060000, 1'b1, -1, 0,  1'b0};
    vt[6]  = '{2'd1, 24'h0F0000, 1'b1, -1, 0,  1'b0};
    vt[7]  = '{2'd2, 24'h001234, 1'b1, 3,  3,  1'b0};
    vt[8]  = '{2'd0, 24'hFFFFFF, 1'b0, 23, 5,  1'b0};
    vt[9]  = '{2'd3, 24'hFFFFFF, 1'b0, 2,  1,  1'b0};
    vt[10] = '{2'd1, 24'h800000, 1'b0, 10, 4,  1'b0};
    vt[11] = '{2'd2, 24'h2FFFFF, 1'b0, 7,  15, 1'b0};

    bus.pcb = '0; bus.m68k_a = '0;
    bus.m68k_rw = 1'b1; bus.m68k_as_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset", "outputs",
        {bus.region_cs, bus.region_wr_stb, bus.dtack_n,
         bus.berr_n, bus.unmapped, bus.overlap},
        {{2*NR{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0});

    for (int i = 0; i < 12; i++)
      access(vt[i].p, vt[i].a, vt[i].rw, vt[i].win, vt[i].w,
             vt[i].ov, $sformatf("vec%0d", i));

    // Abort while in DECODE: nothing may be selected or acked.
    bus.m68k_as_n = 1'b1;
    repeat (2) @(negedge clk);
    bus.pcb = 2'd1; bus.m68k_a = 24'h001234; bus.m68k_rw = 1'b0;
    bus.m68k_as_n = 1'b0;
    @(negedge clk);
    bus.m68k_as_n = 1'b1;
    for (int j = 1; j < 6; j++) begin
      @(negedge clk);
      chk("abort_dec", "idle_outs",
          {bus.region_cs, bus.region_wr_stb, bus.dtack_n},
          {{2*NR{1'b0}}, 1'b1});
    end

    // Abort while in WAIT on region 6.
    repeat (2) @(negedge clk);
    bus.pcb = 2'd1; bus.m68k_a = 24'h06D100; bus.m68k_rw = 1'b0;
    bus.m68k_as_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_wait", "cs_in_wait", 32'(bus.region_cs), 32'h40);
    bus.m68k_as_n = 1'b1;
    for (int j = 2; j < 8; j++) begin
      @(negedge clk);
      chk("abort_wait", "idle_outs",
          {bus.region_cs, bus.region_wr_stb, bus.dtack_n},
          {{2*NR{1'b0}}, 1'b1});
    end

    // Reset in the middle of ACK with the strobe still low.
    repeat (2) @(negedge clk);
    bus.pcb = 2'd1; bus.m68k_a = 24'h001234; bus.m68k_rw = 1'b1;
    bus.m68k_as_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", "dtack_before", 32'(bus.dtack_n), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", "outputs",
        {bus.region_cs, bus.region_wr_stb, bus.dtack_n,
         bus.berr_n, bus.unmapped, bus.overlap},
        {{2*NR{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0});
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("rst_ack", "no_redecode",
          {bus.region_cs, bus.dtack_n}, {{NR{1'b0}}, 1'b1});
    end
    access(2'd2, 24'h001234, 1'b1, 3, 3, 1'b0, "rst_p2");

    // Random accesses near region edges, checked by the model.
    for (int i = 0; i < 30; i++) begin
      p   = 2'($urandom_range(0, NP-1));
      r   = $urandom_range(0, NR-1);
      sel = $urandom_range(0, 4);
      {s, e} = TBL[(int'(p)*NR+r)*2*AW +: 2*AW];
      case (sel)
        0: a = s;
        1: a = e;
        2: a = s - 24'd1;
        3: a = e + 24'd1;
        default: a = 24'($urandom);
      endcase
      win = ref_win(int'(p), a, ov);
      exp_w = (win >= 0) ? int'(WT[win*4 +: 4]) : 0;
      access(p, a, 1'($urandom), win, exp_w, ov,
             $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
